wlmont_iter_red: RTL and testbench

- Iterative, multi-cycle word-level Montgomery reduction for NTT-friendly primes q = qH*2^W + 1.
- Holds the running value T in a register and applies one W-bit reduction step per clock: T <- qH*m + (T >> W) + carry, where m = (-T) mod 2^W.
- The number of steps is selectable per transaction, up to MAX_ITER. An optional final conditional subtraction produces a canonical residue.
- Sits between the modular multiplier's integer product and the NTT butterfly or pointwise datapath, with valid/ready handshakes on both sides.

---
 rtl/wlmont_iter_red.sv | 116 +++++++++++
 tb/tb_wlmont_iter_red.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wlmont_iter_red.sv
// Iterative word-level Montgomery reduction: one W-bit step per clock on a held
// value T, optional final conditional subtraction of q = qH*2^W + 1.
module wlmont_iter_red #(
   parameter int LOGQ      = 31,
   parameter int W         = 16,
   parameter int MAX_ITER  = 2,
   parameter int LOGT      = 2*LOGQ,
   parameter int FINAL_SUB = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [LOGQ-W-1:0]               qH,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [LOGT-1:0]                 in_T,
   input  logic [$clog2(MAX_ITER+1)-1:0]   in_iters,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [LOGQ-1:0]                 out_R,
   output logic                            busy
);

   localparam int TW  = (LOGT > LOGQ+1) ? LOGT : LOGQ+1;
   localparam int IW  = $clog2(MAX_ITER+1);
   // Step sum: widest addend plus one carry bit, never truncated before storing.
   localparam int SW  = ((LOGQ > TW-W) ? LOGQ : TW-W) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ITER = 2'd1;
   localparam logic [1:0] S_SUB  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [IW-1:0] K_ONE = IW'(1);
   localparam logic [IW-1:0] K_MAX = IW'(MAX_ITER);

   logic [1:0]      state;
   logic [TW-1:0]   t_q;
   logic [IW-1:0]   cnt;
   logic [IW-1:0]   k_eff;
   logic [W-1:0]    m;
   logic            carry;
   logic [LOGQ-1:0] prod;
   logic [SW-1:0]   sum;
   logic [TW-1:0]   q_t;
   logic [LOGQ-1:0] sub_r;

   // Handshakes: a transfer happens on a clock edge where valid and ready are
   // both high; valid never depends on ready, and payloads hold while valid waits.
   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);

   always_comb begin
      k_eff = in_iters;
      if (in_iters == '0)
         k_eff = K_ONE;
      else if (in_iters > K_MAX)
         k_eff = K_MAX;
   end

   // (T + m*q) / 2^W computed as qH*m + (T >> W) + carry, since T + m = 0 mod 2^W.
   always_comb begin
      m     = W'(0) - t_q[W-1:0];
      carry = |t_q[W-1:0];
      prod  = LOGQ'(qH) * LOGQ'(m);
      sum   = SW'(prod) + SW'(t_q[TW-1:W]) + SW'(carry);
   end

   always_comb begin
      q_t   = {{(TW-LOGQ){1'b0}}, qH, {W{1'b0}}} + TW'(1);
      sub_r = t_q[LOGQ-1:0];
      if (t_q >= q_t)
         sub_r = t_q[LOGQ-1:0] - q_t[LOGQ-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         t_q   <= '0;
         cnt   <= '0;
         out_R <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  t_q   <= TW'(in_T);
                  cnt   <= k_eff;
                  state <= S_ITER;
               end
            end
            S_ITER: begin
               t_q <= TW'(sum);
               cnt <= cnt - K_ONE;
               if (cnt == K_ONE) begin
                  if (FINAL_SUB != 0) begin
                     state <= S_SUB;
                  end else begin
                     out_R <= sum[LOGQ-1:0];
                     state <= S_DONE;
                  end
               end
            end
            S_SUB: begin
               out_R <= sub_r;
               state <= S_DONE;
            end
            S_DONE: begin
               if (out_ready)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wlmont_iter_red.sv
// Directed bench for wlmont_iter_red with q = 7681, W = 8: a modular-inverse
// model predicts every result, and hand-computed literals pin that model.
module tb_wlmont_iter_red;

   localparam int     LOGQ     = 13;
   localparam int     W        = 8;
   localparam int     MAX_ITER = 2;
   localparam int     LOGT     = 2*LOGQ;
   localparam longint Q        = 30*256 + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [4:0]      qH = 5'd30;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [LOGT-1:0] in_T = '0;
   logic [1:0]      in_iters = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [LOGQ-1:0] out_R;
   logic            busy;

   logic [LOGQ-1:0] exp_q[$];
   logic [LOGQ-1:0] last_r = '0;
   int              errors = 0;
   int              checks = 0;
   int              n_out  = 0;
   longint          rinv   = 0;

   wlmont_iter_red #(
      .LOGQ(LOGQ), .W(W), .MAX_ITER(MAX_ITER), .LOGT(LOGT), .FINAL_SUB(1)
   ) dut (
      .clk(clk), .rst(rst), .qH(qH),
      .in_valid(in_valid), .in_ready(in_ready), .in_T(in_T), .in_iters(in_iters),
      .out_valid(out_valid), .out_ready(out_ready), .out_R(out_R), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // R = T * (2^W)^(-k) mod q, straight modular arithmetic
   function automatic longint model(input longint t, input int k);
      longint r;
      r = t % Q;
      for (int i = 0; i < k; i++)
         r = (r * rinv) % Q;
      return r;
   endfunction

   function automatic int clamp(input int it);
      if (it == 0) return 1;
      if (it > MAX_ITER) return MAX_ITER;
      return it;
   endfunction

   // scoreboard: every accepted result is compared with the queued prediction
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got out_R=%0d, expected no output", out_R);
         end else begin
            check("model_out_R", longint'(out_R), longint'(exp_q.pop_front()));
         end
         last_r = out_R;
         n_out++;
      end
   end

   // driver tasks
   task automatic send(input longint t, input int it, output bit ok);
      int n;
      in_T     = LOGT'(t);
      in_iters = 2'(it);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      ok = in_ready;
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: in_ready=0 after %0d cycles, expected 1", n);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      exp_q.push_back(LOGQ'(model(t, clamp(it))));
      #1 in_valid = 1'b0;
   endtask

   task automatic txn(input longint t, input int it, input longint lit, input string name);
      bit ok;
      int start, lat, low, c, k;
      k = clamp(it);
      start = n_out;
      send(t, it, ok);
      if (!ok) return;
      lat = -1;
      low = 0;
      c = 0;
      while (!in_ready && c < 20) begin
         low++;
         if (out_valid && lat < 0) lat = c;
         @(posedge clk); #1;
         c++;
      end
      check({name, "_latency"}, lat, k + 1);
      check({name, "_busy_cycles"}, low, k + 2);
      check({name, "_one_output"}, n_out, start + 1);
      check({name, "_literal"}, longint'(last_r), lit);
   endtask

   initial begin
      bit     ok;
      int     start, n;
      logic [LOGQ-1:0] held;

      for (longint i = 1; i < Q; i++)
         if ((i * 256) % Q == 1) rinv = i;

      #1;
      check("model_rinv", rinv, 7651);
      check("reset_in_ready", longint'(in_ready), 1);
      check("reset_out_valid", longint'(out_valid), 0);
      check("reset_busy", longint'(busy), 0);
      check("reset_out_R", longint'(out_R), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;

      txn(1,        1, 7651, "t1_k1");
      txn(1,        2, 900,  "t1_k2");
      txn(7681,     1, 0,    "tq_k1");
      txn(256,      1, 1,    "t256_k1");
      txn(0,        1, 0,    "t0_k1");
      txn(58982400, 2, 900,  "tsq_k2");
      txn(1,        0, 7651, "clamp_k0");
      txn(1,        3, 900,  "clamp_k3");
      txn(7680,     1, 30,   "t7680_k1");
      txn(1966335,  1, 30,   "tmax_k1");

      // backpressure in DONE
      out_ready = 1'b0;
      start = n_out;
      send(1966335, 1, ok);
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp_reach_done", longint'(out_valid), 1);
      held = out_R;
      check("bp_literal", longint'(held), 30);
      for (int i = 0; i < 10; i++) begin
         in_T     = LOGT'(5);
         in_iters = 2'd1;
         in_valid = (i % 2 == 0);
         @(posedge clk); #1;
         check("bp_out_valid", longint'(out_valid), 1);
         check("bp_out_R_hold", longint'(out_R), longint'(held));
         check("bp_in_ready", longint'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_idle", longint'(in_ready), 1);
      check("bp_release_valid", longint'(out_valid), 0);
      check("bp_single_output", n_out, start + 1);
      repeat (4) @(posedge clk);
      #1;
      check("bp_no_extra_output", n_out, start + 1);

      // asynchronous reset in the middle of ITER
      start = n_out;
      send(1, 2, ok);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", longint'(busy), 0);
      check("arst_in_ready", longint'(in_ready), 1);
      check("arst_out_valid", longint'(out_valid), 0);
      check("arst_out_R", longint'(out_R), 0);
      exp_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("arst_no_output", n_out, start);
      txn(1, 1, 7651, "after_reset");

      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
